// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline. It registers the EX result bus, extracts the load
// data from the one-cycle-latency data SRAM, and drives the MEM->WB and MEM->ID buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_bus
);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    logic [EX_TO_MEM_WD-1:0] r_q, r_d;
    logic                    first_q, first_d;
    logic [31:0]             rdata_hold_q, rdata_hold_d;

    logic        stop_ex_mem;
    logic        stop_mem_wb;
    logic        r_load;

    logic [31:0] pc;
    logic [2:0]  ld_op;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    logic [31:0] raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;
    logic [31:0] rf_wdata;

    // Store strobes and enables only matter to EX, which already issued the access.
    logic        unused_fields;

    assign stop_ex_mem = stall[3];
    assign stop_mem_wb = stall[4];

    // r takes a new value (instruction or bubble) unless both sides of it are stopped.
    assign r_load = !(stop_ex_mem && stop_mem_wb);

    always_comb begin
        r_d = r_q;
        if (stop_ex_mem && !stop_mem_wb) begin
            r_d = '0;
        end else if (!stop_ex_mem) begin
            r_d = ex_to_mem_bus;
        end
    end

    // SRAM data is only valid the cycle after the address; capture it then so a stalled
    // load keeps returning the same value.
    always_comb begin
        first_d      = r_load;
        rdata_hold_d = rdata_hold_q;
        if (first_q) begin
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            first_q      <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            r_q          <= r_d;
            first_q      <= first_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign pc         = r_q[78:47];
    assign ld_op      = r_q[46:44];
    assign ram_en     = r_q[43];
    assign ram_wen    = r_q[42:39];
    assign sel_rf_res = r_q[38];
    assign rf_we      = r_q[37];
    assign rf_waddr   = r_q[36:32];
    assign ex_result  = r_q[31:0];

    assign unused_fields = ^{ram_en, ram_wen, stall[5], stall[2:0]};

    assign raw = first_q ? data_sram_rdata : rdata_hold_q;

    always_comb begin
        ld_byte = raw[7:0];
        case (ex_result[1:0])
            2'd0: ld_byte = raw[7:0];
            2'd1: ld_byte = raw[15:8];
            2'd2: ld_byte = raw[23:16];
            2'd3: ld_byte = raw[31:24];
            default: ld_byte = raw[7:0];
        endcase
        ld_half = ex_result[1] ? raw[31:16] : raw[15:0];
    end

    // Reserved ld_op codes fall through to a full-word load.
    always_comb begin
        load_result = raw;
        case (ld_op)
            LD_LW:   load_result = raw;
            LD_LB:   load_result = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  load_result = {24'h0, ld_byte};
            LD_LH:   load_result = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  load_result = {16'h0, ld_half};
            default: load_result = raw;
        endcase
    end

    assign rf_wdata = sel_rf_res ? load_result : ex_result;

    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU passthrough, load extraction, stall hold,
// bubble insertion and reset during a stall.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;

    int vectors;
    int miscompares;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [78:0] mk_bus(input logic [31:0] pc, input logic [2:0] op,
                                           input logic en, input logic [3:0] wen,
                                           input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res);
        return {pc, op, en, wen, sel, we, waddr, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [69:0] exp);
        check({tag, "_wb"}, mem_to_wb_bus, exp);
        check({tag, "_id"}, {32'h0, mem_to_id_bus}, {32'h0, exp[37:0]});
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] lane,
                           input logic [31:0] exp_data);
        ex_to_mem_bus   = mk_bus(32'h0040_0100, op, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,
                                 {30'h0000_0400, lane});
        data_sram_rdata = 32'h0;
        tick();
        data_sram_rdata = 32'h8081_7F02;
        #1;
        check_both(tag, {32'h0040_0100, 1'b1, 5'd9, exp_data});
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        stall           = 6'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        ex_to_mem_bus   = mk_bus(32'hBFC0_0000, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);

        // Reset held for two clocks with a live bus
        tick();
        check_both("reset1", 70'h0);
        tick();
        check_both("reset2", 70'h0);

        // ALU passthrough
        rst           = 1'b0;
        ex_to_mem_bus = mk_bus(32'h0040_0000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
        tick();
        check_both("alu", {32'h0040_0000, 1'b1, 5'd5, 32'h1234_5678});

        // Store: rf_we passes through as 0, result is the address
        ex_to_mem_bus = mk_bus(32'h0040_0004, 3'b000, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0200);
        tick();
        check_both("store", {32'h0040_0004, 1'b0, 5'd0, 32'h0000_0200});

        // Load extraction on 0x8081_7F02 (bytes LE: 02,7F,81,80)
        do_load("lb_a2",  3'b001, 2'd2, 32'hFFFF_FF81);
        do_load("lbu_a2", 3'b010, 2'd2, 32'h0000_0081);
        do_load("lb_a1",  3'b001, 2'd1, 32'h0000_007F);
        do_load("lb_a0",  3'b001, 2'd0, 32'h0000_0002);
        do_load("lb_a3",  3'b001, 2'd3, 32'hFFFF_FF80);
        do_load("lbu_a3", 3'b010, 2'd3, 32'h0000_0080);
        do_load("lh_a2",  3'b011, 2'd2, 32'hFFFF_8081);
        do_load("lhu_a2", 3'b100, 2'd2, 32'h0000_8081);
        do_load("lh_a3",  3'b011, 2'd3, 32'hFFFF_8081);
        do_load("lh_a0",  3'b011, 2'd0, 32'h0000_7F02);
        do_load("lw",     3'b000, 2'd0, 32'h8081_7F02);
        do_load("op101",  3'b101, 2'd2, 32'h8081_7F02);
        do_load("op111",  3'b111, 2'd1, 32'h8081_7F02);

        // sel_rf_res=0 with a load op ignores SRAM
        ex_to_mem_bus = mk_bus(32'h0040_0200, 3'b001, 1'b1, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0000_0402);
        tick();
        data_sram_rdata = 32'hAAAA_5555;
        #1;
        check_both("nosel", {32'h0040_0200, 1'b1, 5'd3, 32'h0000_0402});

        // Stall hold: lw stays in MEM for 3 stalled cycles while SRAM data changes
        ex_to_mem_bus = mk_bus(32'h0040_0300, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h0000_0100);
        tick();
        data_sram_rdata = 32'hCAFE_BABE;
        #1;
        check_both("hold0", {32'h0040_0300, 1'b1, 5'd7, 32'hCAFE_BABE});
        stall         = 6'b011000;
        ex_to_mem_bus = mk_bus(32'h0040_0304, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0BAD_0BAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_rdata = 32'hDEAD_0000 + 32'(i);
            #1;
            check_both($sformatf("hold%0d", i + 1), {32'h0040_0300, 1'b1, 5'd7, 32'hCAFE_BABE});
        end
        stall = 6'b0;
        tick();
        check_both("hold_rel", {32'h0040_0304, 1'b1, 5'd8, 32'h0BAD_0BAD});

        // Bubble: EX/MEM stopped, MEM/WB running
        ex_to_mem_bus = mk_bus(32'h0040_0400, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h0000_1111);
        tick();
        check_both("pre_bub", {32'h0040_0400, 1'b1, 5'd10, 32'h0000_1111});
        stall         = 6'b001000;
        ex_to_mem_bus = mk_bus(32'h0040_0404, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'h0000_2222);
        tick();
        check_both("bubble", 70'h0);
        stall = 6'b0;
        tick();
        check_both("post_bub", {32'h0040_0404, 1'b1, 5'd11, 32'h0000_2222});

        // Reset during a stalled load
        ex_to_mem_bus = mk_bus(32'h0040_0500, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_0104);
        tick();
        data_sram_rdata = 32'hCAFE_BABE;
        #1;
        check_both("rs_ld", {32'h0040_0500, 1'b1, 5'd12, 32'hCAFE_BABE});
        stall = 6'b011000;
        tick();
        data_sram_rdata = 32'hDEAD_0000;
        #1;
        check_both("rs_c1", {32'h0040_0500, 1'b1, 5'd12, 32'hCAFE_BABE});
        rst = 1'b1;
        tick();
        check_both("rs_rst", 70'h0);
        rst = 1'b0;
        tick();
        check_both("rs_after", 70'h0);
        stall         = 6'b0;
        ex_to_mem_bus = mk_bus(32'h0040_0600, 3'b011, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_0106);
        tick();
        data_sram_rdata = 32'h1122_3344;
        #1;
        check_both("rs_next", {32'h0040_0600, 1'b1, 5'd13, 32'h0000_1122});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
